// File: rtl/seq_threshold_voter_if.sv
// Ballot-stream and decision handshake bundle for seq_threshold_voter.
// The master side produces ballots and consumes decisions. The slave side is the voter.
interface seq_threshold_voter_if #(
  parameter int N         = 16,
  parameter int MAX_BEATS = 8
);
  localparam int CW = $clog2(N * MAX_BEATS + 1);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_last;
  logic          in_thr_mode;
  logic [CW-1:0] in_thr;
  logic          in_tie;

  logic          out_valid;
  logic          out_ready;
  logic          out_vote;
  logic [CW-1:0] out_count;
  logic [CW-1:0] out_total;
  logic          out_err;

  modport master (
    output in_valid, in_data, in_last, in_thr_mode, in_thr, in_tie, out_ready,
    input  in_ready, out_valid, out_vote, out_count, out_total, out_err
  );

  modport slave (
    input  in_valid, in_data, in_last, in_thr_mode, in_thr, in_tie, out_ready,
    output in_ready, out_valid, out_vote, out_count, out_total, out_err
  );
endinterface

// File: rtl/seq_threshold_voter.sv
// Streaming threshold/majority voter. It accumulates ballot popcounts over a frame and emits one registered decision.
// Optional feature macro: VOTER_TIE_BREAK_EN makes a majority-mode tie resolve to the in_tie latched on the first beat.
module seq_threshold_voter #(
  parameter int N         = 16,
  parameter int MAX_BEATS = 8
) (
  input logic                clk,
  input logic                rst_n,
  seq_threshold_voter_if.slave bus
);
  localparam int CW = $clog2(N * MAX_BEATS + 1);
  localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t        state, state_next;
  logic [CW-1:0] acc, tot;
  logic [BW-1:0] beat_cnt;
  logic          mode_q;
  logic [CW-1:0] thr_q;

  logic          accept, first, closing;
  logic [CW-1:0] pop, acc_next, tot_next;
  logic          mode_eff;
  logic [CW-1:0] thr_eff;
  logic          tie_eff;
  logic          vote_next;

`ifdef VOTER_TIE_BREAK_EN
  logic tie_q;
`else
  // in_tie has no function in this build. Naming it unused records that on purpose.
  logic unused_tie;
  assign unused_tie = bus.in_tie;
`endif

  // ---------------- FSM: state register ----------------
  // NOTE: all clocked state uses non-blocking (<=) so every flop samples pre-edge values; blocking is for comb only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  // ---------------- FSM: next-state logic ----------------
  // NOTE: every comb output gets a default before any branch, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ACCUM: if (closing)           state_next = HOLD;
      HOLD:  if (bus.out_ready)     state_next = ACCUM;
      default:                      state_next = ACCUM;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // in_ready depends only on state, so out_ready never reaches it combinationally.
  always_comb begin
    bus.in_ready = (state == ACCUM);
  end

  // ---------------- Datapath ----------------
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + CW'(bus.in_data[i]);
  end

  assign accept   = bus.in_valid && bus.in_ready;
  assign first    = (beat_cnt == '0);
  assign closing  = accept && (bus.in_last || (beat_cnt == BW'(MAX_BEATS - 1)));
  assign acc_next = acc + pop;
  assign tot_next = tot + CW'(N);

  // A single-beat frame must use this beat's controls, so the first beat bypasses the latches.
  assign mode_eff = first ? bus.in_thr_mode : mode_q;
  assign thr_eff  = first ? bus.in_thr      : thr_q;

`ifdef VOTER_TIE_BREAK_EN
  assign tie_eff = first ? bus.in_tie : tie_q;
`else
  assign tie_eff = 1'b0;
`endif

  // Doubling is done one bit wider so that 2*count cannot wrap.
  always_comb begin
    logic [CW:0] dbl;
    logic [CW:0] tot_ext;
    dbl       = {acc_next, 1'b0};
    tot_ext   = {1'b0, tot_next};
    vote_next = 1'b0;
    if (mode_eff) vote_next = (acc_next >= thr_eff);
    else if (dbl > tot_ext)  vote_next = 1'b1;
    else if (dbl == tot_ext) vote_next = tie_eff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= '0;
      tot           <= '0;
      beat_cnt      <= '0;
      mode_q        <= 1'b0;
      thr_q         <= '0;
`ifdef VOTER_TIE_BREAK_EN
      tie_q         <= 1'b0;
`endif
      bus.out_valid <= 1'b0;
      bus.out_vote  <= 1'b0;
      bus.out_count <= '0;
      bus.out_total <= '0;
      bus.out_err   <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            if (first) begin
              mode_q <= bus.in_thr_mode;
              thr_q  <= bus.in_thr;
`ifdef VOTER_TIE_BREAK_EN
              tie_q  <= bus.in_tie;
`endif
            end
            if (closing) begin
              bus.out_valid <= 1'b1;
              bus.out_vote  <= vote_next;
              bus.out_count <= acc_next;
              bus.out_total <= tot_next;
              bus.out_err   <= !bus.in_last;
            end else begin
              acc      <= acc_next;
              tot      <= tot_next;
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        HOLD: begin
          // The decision registers stay as they are. Only the frame state is cleared for the next frame.
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            acc           <= '0;
            tot           <= '0;
            beat_cnt      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // A stalled decision must not change under the consumer.
  hold_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=>
      $stable({bus.out_valid, bus.out_vote, bus.out_count, bus.out_total, bus.out_err}));

endmodule

// File: tb/tb_seq_threshold_voter.sv
// Directed testbench for seq_threshold_voter (N=16, MAX_BEATS=8, CW=8).
// Expected decisions are hand-derived. The tie result follows VOTER_TIE_BREAK_EN.
module tb_seq_threshold_voter;
  localparam int N         = 16;
  localparam int MAX_BEATS = 8;
  localparam int CW        = $clog2(N * MAX_BEATS + 1);

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  seq_threshold_voter_if #(.N(N), .MAX_BEATS(MAX_BEATS)) vif ();

  seq_threshold_voter #(.N(N), .MAX_BEATS(MAX_BEATS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents one beat and waits a bounded number of cycles until it is accepted.
  task automatic drive_beat(input logic [N-1:0] data, input logic last,
                            input logic mode, input logic [CW-1:0] thr, input logic tie);
    int waited;
    vif.in_valid    = 1'b1;
    vif.in_data     = data;
    vif.in_last     = last;
    vif.in_thr_mode = mode;
    vif.in_thr      = thr;
    vif.in_tie      = tie;
    waited = 0;
    while (!vif.in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (!vif.in_ready) begin
      errors++;
      $display("FAIL beat_accept_timeout: in_ready=%b required 1", vif.in_ready);
    end
    @(posedge clk); #1;
    vif.in_valid = 1'b0;
  endtask

  task automatic consume();
    vif.out_ready = 1'b1;
    @(posedge clk); #1;
    vif.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (vif.in_ready  !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", vif.in_ready); end
    checks++; if (vif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", vif.out_valid); end
    checks++; if (vif.out_vote  !== 1'b0) begin errors++; $display("FAIL reset_out_vote: got %b want 0", vif.out_vote); end
    checks++; if (vif.out_count !== 8'd0) begin errors++; $display("FAIL reset_out_count: got %0d want 0", vif.out_count); end
    checks++; if (vif.out_total !== 8'd0) begin errors++; $display("FAIL reset_out_total: got %0d want 0", vif.out_total); end
    checks++; if (vif.out_err   !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b want 0", vif.out_err); end
  endtask

  task automatic test_single_beat_tie();
    logic exp_vote;
`ifdef VOTER_TIE_BREAK_EN
    exp_vote = 1'b1;
`else
    exp_vote = 1'b0;
`endif
    drive_beat(16'h00FF, 1'b1, 1'b0, 8'd0, 1'b1);
    checks++; if (vif.out_valid !== 1'b1)  begin errors++; $display("FAIL tie_latency: out_valid=%b want 1", vif.out_valid); end
    checks++; if (vif.out_count !== 8'd8)  begin errors++; $display("FAIL tie_count: got %0d want 8", vif.out_count); end
    checks++; if (vif.out_total !== 8'd16) begin errors++; $display("FAIL tie_total: got %0d want 16", vif.out_total); end
    checks++; if (vif.out_vote  !== exp_vote) begin errors++; $display("FAIL tie_vote: got %b want %b", vif.out_vote, exp_vote); end
    checks++; if (vif.in_ready  !== 1'b0)  begin errors++; $display("FAIL tie_hold_ready: got %b want 0", vif.in_ready); end
    consume();
    checks++; if (vif.out_valid !== 1'b0 || vif.in_ready !== 1'b1) begin
      errors++; $display("FAIL tie_release: out_valid=%b in_ready=%b want 0/1", vif.out_valid, vif.in_ready);
    end
  endtask

  task automatic test_majority_multi();
    drive_beat(16'hFFFF, 1'b0, 1'b0, 8'd0, 1'b0);
    checks++; if (vif.out_valid !== 1'b0) begin errors++; $display("FAIL maj_midframe_valid: got %b want 0", vif.out_valid); end
    drive_beat(16'h0001, 1'b0, 1'b0, 8'd0, 1'b0);
    drive_beat(16'h0000, 1'b1, 1'b0, 8'd0, 1'b0);
    checks++; if (vif.out_valid !== 1'b1)  begin errors++; $display("FAIL maj_valid: got %b want 1", vif.out_valid); end
    checks++; if (vif.out_count !== 8'd17) begin errors++; $display("FAIL maj_count: got %0d want 17", vif.out_count); end
    checks++; if (vif.out_total !== 8'd48) begin errors++; $display("FAIL maj_total: got %0d want 48", vif.out_total); end
    checks++; if (vif.out_vote  !== 1'b0)  begin errors++; $display("FAIL maj_vote: got %b want 0", vif.out_vote); end
    checks++; if (vif.out_err   !== 1'b0)  begin errors++; $display("FAIL maj_err: got %b want 0", vif.out_err); end
    consume();
  endtask

  task automatic test_threshold();
    drive_beat(16'h000F, 1'b0, 1'b1, 8'd5, 1'b0);
    drive_beat(16'h0001, 1'b1, 1'b1, 8'd5, 1'b0);
    checks++; if (vif.out_count !== 8'd5) begin errors++; $display("FAIL thr5_count: got %0d want 5", vif.out_count); end
    checks++; if (vif.out_vote  !== 1'b1) begin errors++; $display("FAIL thr5_vote: got %b want 1", vif.out_vote); end
    consume();
    // thr=6 on the first beat, then 0 mid-frame. The mid-frame value must be ignored.
    drive_beat(16'h000F, 1'b0, 1'b1, 8'd6, 1'b0);
    drive_beat(16'h0001, 1'b1, 1'b1, 8'd0, 1'b0);
    checks++; if (vif.out_count !== 8'd5) begin errors++; $display("FAIL thr6_count: got %0d want 5", vif.out_count); end
    checks++; if (vif.out_vote  !== 1'b0) begin errors++; $display("FAIL thr6_vote: got %b want 0", vif.out_vote); end
    consume();
    drive_beat(16'h0000, 1'b1, 1'b1, 8'd0, 1'b0);
    checks++; if (vif.out_vote !== 1'b1) begin errors++; $display("FAIL thr0_vote: got %b want 1", vif.out_vote); end
    consume();
    drive_beat(16'hFFFF, 1'b1, 1'b1, 8'd200, 1'b0);
    checks++; if (vif.out_vote !== 1'b0) begin errors++; $display("FAIL thr_over_vote: got %b want 0", vif.out_vote); end
    consume();
  endtask

  task automatic test_max_beats();
    for (int b = 0; b < MAX_BEATS; b++) begin
      drive_beat(16'hFFFF, 1'b0, 1'b0, 8'd0, 1'b0);
      if (b == MAX_BEATS - 2) begin
        checks++; if (vif.out_valid !== 1'b0) begin errors++; $display("FAIL max_early_close: out_valid=%b after beat 7 want 0", vif.out_valid); end
      end
    end
    checks++; if (vif.out_valid !== 1'b1)   begin errors++; $display("FAIL max_valid: got %b want 1", vif.out_valid); end
    checks++; if (vif.out_count !== 8'd128) begin errors++; $display("FAIL max_count: got %0d want 128", vif.out_count); end
    checks++; if (vif.out_total !== 8'd128) begin errors++; $display("FAIL max_total: got %0d want 128", vif.out_total); end
    checks++; if (vif.out_err   !== 1'b1)   begin errors++; $display("FAIL max_err: got %b want 1", vif.out_err); end
    checks++; if (vif.out_vote  !== 1'b1)   begin errors++; $display("FAIL max_vote: got %b want 1", vif.out_vote); end
    consume();
    drive_beat(16'h0001, 1'b1, 1'b0, 8'd0, 1'b0);
    checks++; if (vif.out_count !== 8'd1 || vif.out_total !== 8'd16 || vif.out_err !== 1'b0 || vif.out_vote !== 1'b0) begin
      errors++; $display("FAIL max_next_clean: count=%0d total=%0d err=%b vote=%b want 1/16/0/0",
                         vif.out_count, vif.out_total, vif.out_err, vif.out_vote);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic stable_ok;
    drive_beat(16'h0007, 1'b1, 1'b1, 8'd3, 1'b0);
    // The next beat waits while the decision is stalled.
    vif.in_valid    = 1'b1;
    vif.in_data     = 16'hFFFF;
    vif.in_last     = 1'b1;
    vif.in_thr_mode = 1'b0;
    vif.in_thr      = 8'd0;
    stable_ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (vif.in_ready !== 1'b0 || vif.out_valid !== 1'b1 || vif.out_count !== 8'd3 ||
          vif.out_total !== 8'd16 || vif.out_vote !== 1'b1 || vif.out_err !== 1'b0) stable_ok = 1'b0;
      @(posedge clk); #1;
    end
    checks++; if (stable_ok !== 1'b1) begin
      errors++; $display("FAIL stall_stable: in_ready=%b out_valid=%b count=%0d vote=%b want 0/1/3/1",
                         vif.in_ready, vif.out_valid, vif.out_count, vif.out_vote);
    end
    vif.out_ready = 1'b1;
    @(posedge clk); #1;
    vif.out_ready = 1'b0;
    checks++; if (vif.out_valid !== 1'b0 || vif.in_ready !== 1'b1) begin
      errors++; $display("FAIL bubble_cycle: out_valid=%b in_ready=%b want 0/1", vif.out_valid, vif.in_ready);
    end
    @(posedge clk); #1;
    vif.in_valid = 1'b0;
    checks++; if (vif.out_valid !== 1'b1 || vif.out_count !== 8'd16) begin
      errors++; $display("FAIL after_bubble_accept: out_valid=%b count=%0d want 1/16", vif.out_valid, vif.out_count);
    end
    consume();
  endtask

  task automatic test_reset_midframe();
    drive_beat(16'hFFFF, 1'b0, 1'b0, 8'd0, 1'b0);
    drive_beat(16'hFFFF, 1'b0, 1'b0, 8'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (vif.out_count !== 8'd0 || vif.out_total !== 8'd0 || vif.out_valid !== 1'b0 ||
                  vif.in_ready !== 1'b1 || vif.out_vote !== 1'b0 || vif.out_err !== 1'b0) begin
      errors++; $display("FAIL midframe_reset: count=%0d total=%0d valid=%b ready=%b want 0/0/0/1",
                         vif.out_count, vif.out_total, vif.out_valid, vif.in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_beat(16'h0003, 1'b1, 1'b1, 8'd2, 1'b0);
    checks++; if (vif.out_count !== 8'd2 || vif.out_total !== 8'd16 || vif.out_vote !== 1'b1) begin
      errors++; $display("FAIL post_reset_frame: count=%0d total=%0d vote=%b want 2/16/1",
                         vif.out_count, vif.out_total, vif.out_vote);
    end
    consume();
  endtask

  initial begin
    rst_n           = 1'b0;
    vif.in_valid    = 1'b0;
    vif.in_data     = '0;
    vif.in_last     = 1'b0;
    vif.in_thr_mode = 1'b0;
    vif.in_thr      = '0;
    vif.in_tie      = 1'b0;
    vif.out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_single_beat_tie();
    test_majority_multi();
    test_threshold();
    test_max_beats();
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
